tick_rr_scheduler: RTL and testbench
====================================

Name: tick_rr_scheduler

Overview:
Controller for a shared enabled 1-bit register: d input, load enable and q output, with q updated only when enable is high. It replaces the derived slow clock with a single-domain tick counter on clk. It shares the register's load port between N_REQ requesters using round-robin arbitration, one load per tick. It also supports a single-step input for board debugging.

Parameters:
N_REQ, 4, number of requesters (2..8).
DIV, 50000000, tick period in clk cycles (>= 2).
CNT_W, 26, tick counter width; must satisfy 2^CNT_W >= DIV.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
run  in  1  1 = free-running tick counter advances; 0 = counter holds.
step  in  1  1-cycle pulse forces a tick in the same cycle, regardless of run.
req  in  N_REQ  per-requester load request; level, held until ack.
req_d  in  N_REQ  per-requester data bit; req_d[i] is paired with req[i].
tick  out  1  combinational; high in the cycle a tick occurs.
reg_en  out  1  registered 1-cycle load enable to the shared register.
reg_d  out  1  registered data to the shared register; valid when reg_en=1.
grant  out  N_REQ  registered one-hot owner of the last load; held until the next tick.
ack  out  N_REQ  registered 1-cycle one-hot pulse to the served requester.

Behaviour:
- Reset (async, active-high): cnt=0, reg_en=0, reg_d=0, grant=0, ack=0, rr pointer last=N_REQ-1, so req[0] has first priority. Outputs read 0 while reset is held.
- Counter:
  - When run=1: cnt increments each clk; at cnt==DIV-1 it wraps to 0.
  - When run=0: cnt holds its value.
  - Step: on a cycle with step=1, cnt is loaded with 0.
- Tick: tick = step | (run & cnt==DIV-1).
  - step and a natural tick in the same cycle produce exactly one tick.
  - With run=1 and no step, ticks occur every DIV cycles.
- Arbitration, evaluated only in tick cycles:
  - The winner w is the first i with req[i]=1, scanning last+1, last+2, ... modulo N_REQ.
  - At the clock edge ending a tick cycle with any req set: reg_en<=1, reg_d<=req_d[w], grant<=onehot(w), ack<=onehot(w), last<=w.
  - Tick cycle with no req set: reg_en<=0, ack<=0, grant<=0, last unchanged.
  - Non-tick cycle: reg_en<=0, ack<=0; grant and last hold.
- Latency: reg_en and ack are asserted 1 cycle after the tick cycle, for exactly 1 cycle. The shared register loads on the following edge.
- req is ignored between ticks. A requester deasserts req on seeing ack. If req is still high at the next tick, it competes again (round-robin places it last).
- req_d is sampled only in the winning tick cycle; changes at other times have no effect.
- Reset mid-operation: any pending ack/reg_en pulse is cancelled, cnt=0, and priority returns to req[0].
- No storage of data beyond reg_d; no queueing. Starvation is bounded at N_REQ ticks.

Test Plan:
1. Bench with DIV=4, N_REQ=4. Reset, run=1, no req -> tick high at cycles 3, 7, 11 after release; reg_en, ack and grant stay 0.
2. req=4'b1111, req_d=4'b1010, requesters drop req on ack -> successive ticks grant 0, 1, 2, 3; reg_d=0, 1, 0, 1. Each ack is 1 cycle, one cycle after its tick.
3. req=4'b0101 held continuously -> grants alternate 0, 2, 0, 2; grant holds between ticks.
4. run=0 with step pulses at arbitrary cycles, req[3]=1, req_d[3]=1 -> one tick per step; reg_en=1, reg_d=1, ack[3]=1 the next cycle. cnt stays 0.
5. run=1, step asserted exactly when cnt==3 -> only one tick and one reg_en pulse; the next natural tick follows 4 cycles later.
6. Assert reset in the cycle after a tick, while reg_en=1 -> reg_en, ack and grant drop to 0 immediately. After release, req=4'b1000 then 4'b1001 -> first grant goes to 3, then 0.

Source files
------------

// File: rtl/tick_rr_scheduler_if.sv
// Requester-facing bus of the tick scheduler: requests with paired data in,
// tick strobe and registered load/grant/ack back out.
interface tick_rr_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_d;
  logic             tick;
  logic             reg_en;
  logic             reg_d;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] ack;

  modport master (
    output req, req_d,
    input  tick, reg_en, reg_d, grant, ack
  );

  modport slave (
    input  req, req_d,
    output tick, reg_en, reg_d, grant, ack
  );
endinterface

// File: rtl/tick_rr_scheduler.sv
// Single-domain tick generator sharing one enabled register's load port among
// N_REQ requesters, round-robin, at most one load per tick; step forces a tick.
module tick_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int DIV   = 50000000,
  parameter int CNT_W = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  tick_rr_scheduler_if.slave bus
);
  localparam int             LW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [LW-1:0]  LAST_INIT = LW'(N_REQ - 1);

  logic [CNT_W-1:0] cnt;
  logic [LW-1:0]    last;
  logic [LW-1:0]    win_idx;
  logic [LW-1:0]    scan_idx;
  logic             win_vld;
  logic [N_REQ-1:0] win_oh;
  logic             nat_tick;
  logic             tick;
  int               idx;

  assign nat_tick = run && (cnt == CNT_MAX);
  assign tick     = step | nat_tick;
  assign bus.tick = tick;

  // Scan starts just after the last winner so the previous owner ranks last.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = last;
    idx      = 0;
    scan_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      scan_idx = LW'(idx);
      if (!win_vld && bus.req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
    win_oh = N_REQ'(1) << win_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      last       <= LAST_INIT;
      bus.reg_en <= 1'b0;
      bus.reg_d  <= 1'b0;
      bus.grant  <= '0;
      bus.ack    <= '0;
    end else begin
      if (step)
        cnt <= '0;
      else if (run)
        cnt <= nat_tick ? '0 : cnt + CNT_W'(1);

      bus.reg_en <= tick && win_vld;
      bus.ack    <= (tick && win_vld) ? win_oh : '0;

      // An idle tick clears ownership; between ticks ownership holds.
      if (tick) begin
        if (win_vld) begin
          bus.reg_d <= bus.req_d[win_idx];
          bus.grant <= win_oh;
          last      <= win_idx;
        end else begin
          bus.grant <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_tick_rr_scheduler.sv
// Scoreboard bench for tick_rr_scheduler with DIV=4, N_REQ=4.
module tb_tick_rr_scheduler;
  localparam int N_REQ = 4;
  localparam int DIV   = 4;
  localparam int CNT_W = 2;

  typedef struct {
    int         cyc;
    logic       d;
    logic [3:0] oh;
  } exp_t;

  logic clk = 1'b0;
  logic reset, run, step;
  logic auto_drop;
  logic [3:0] ack_seen;

  tick_rr_scheduler_if #(.N_REQ(N_REQ)) bus ();

  tick_rr_scheduler #(.N_REQ(N_REQ), .DIV(DIV), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .step  (step),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  int   tick_log[$];
  int   grant_log[$];
  logic d_log[$];
  int   m_cnt, m_last, cyc, n, s;
  logic [3:0] m_grant;
  logic m_tick;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    int i;
    for (int k = 1; k <= 4; k++) begin
      i = (last + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // One clock: observe at negedge, then return just after the next rising edge.
  task automatic step_cycle();
    exp_t e;
    int   w;
    @(negedge clk);
    ack_seen = bus.ack;
    if (reset) begin
      chk("rst_reg_en", bus.reg_en, 0);
      chk("rst_ack", bus.ack, 0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_reg_d", bus.reg_d, 0);
      sbq.delete();
      m_cnt   = 0;
      m_last  = 3;
      m_grant = 4'b0;
      cyc     = 0;
    end else begin
      if (bus.reg_en) begin
        if (sbq.size() == 0) begin
          chk("spurious_load", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("load_cyc", cyc, e.cyc);
          chk("reg_d", bus.reg_d, e.d);
          chk("ack", bus.ack, e.oh);
        end
      end else begin
        chk("ack_idle", bus.ack, 0);
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          chk("missed_load", 0, 1);
          void'(sbq.pop_front());
        end
      end
      chk("grant", bus.grant, m_grant);
      m_tick = step | (run && m_cnt == DIV - 1);
      chk("tick", bus.tick, m_tick);
      if (m_tick) begin
        tick_log.push_back(cyc);
        if (bus.req != 4'b0) begin
          w     = rr_pick(bus.req, m_last);
          e.cyc = cyc + 1;
          e.d   = bus.req_d[w];
          e.oh  = 4'b1 << w;
          sbq.push_back(e);
          m_grant = e.oh;
          m_last  = w;
          grant_log.push_back(w);
          d_log.push_back(e.d);
        end else begin
          m_grant = 4'b0;
        end
      end
      if (step) m_cnt = 0;
      else if (run) m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
      cyc++;
    end
    @(posedge clk);
    #1;
    if (auto_drop) bus.req = bus.req & ~ack_seen;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; auto_drop = 1'b0;
    bus.req = 4'b0; bus.req_d = 4'b0; cyc = 0;
    repeat (3) step_cycle();
    reset = 1'b0;
    run   = 1'b1;

    // Free-running, no requests
    tick_log.delete(); grant_log.delete();
    repeat (12) step_cycle();
    chk("t1_nticks", tick_log.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_tick_cyc", tick_log[i], 3 + 4 * i);
    chk("t1_no_grant", grant_log.size(), 0);

    // All request, drop on ack
    grant_log.delete(); d_log.delete();
    bus.req_d = 4'b1010; bus.req = 4'b1111; auto_drop = 1'b1;
    n = 0;
    while (bus.req != 4'b0 && n < 64) begin step_cycle(); n++; end
    chk("t2_timeout", n < 64, 1);
    repeat (2) step_cycle();
    chk("t2_ngrants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_grant", grant_log[i], i);
      chk("t2_reg_d", d_log[i], i % 2);
    end

    // Two requesters held
    auto_drop = 1'b0; grant_log.delete();
    bus.req = 4'b0101;
    repeat (16) step_cycle();
    chk("t3_ngrants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_grant", grant_log[i], (i % 2) * 2);
    bus.req = 4'b0;

    // Single-step with counter stopped
    run = 1'b0; bus.req = 4'b1000; bus.req_d = 4'b1000;
    tick_log.delete(); grant_log.delete(); d_log.delete();
    for (int p = 0; p < 3; p++) begin
      repeat (2 + 2 * p) step_cycle();
      step = 1'b1; step_cycle(); step = 1'b0;
    end
    repeat (2) step_cycle();
    chk("t4_nticks", tick_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t4_grant", grant_log[i], 3);
      chk("t4_reg_d", d_log[i], 1);
    end

    // Step coinciding with a natural tick
    tick_log.delete(); grant_log.delete();
    run = 1'b1; n = 0;
    while (m_cnt != DIV - 1 && n < 10) begin step_cycle(); n++; end
    chk("t5_timeout", n < 10, 1);
    s = cyc;
    step = 1'b1; step_cycle(); step = 1'b0;
    repeat (6) step_cycle();
    chk("t5_nticks", tick_log.size(), 2);
    chk("t5_first", tick_log[0], s);
    chk("t5_second", tick_log[1], s + 4);
    chk("t5_loads", grant_log.size(), 2);

    // Reset while a load pulse is out
    bus.req = 4'b1000; n = 0;
    while (!bus.reg_en && n < 10) begin step_cycle(); n++; end
    chk("t6_timeout", n < 10, 1);
    reset = 1'b1;
    #1;
    chk("t6_reg_en", bus.reg_en, 0);
    chk("t6_ack", bus.ack, 0);
    chk("t6_grant", bus.grant, 0);
    repeat (2) step_cycle();
    reset = 1'b0;
    grant_log.delete(); n = 0;
    while (grant_log.size() < 1 && n < 10) begin step_cycle(); n++; end
    bus.req = 4'b1001;
    while (grant_log.size() < 2 && n < 20) begin step_cycle(); n++; end
    repeat (2) step_cycle();
    chk("t6_ngrants", grant_log.size(), 2);
    chk("t6_first", grant_log[0], 3);
    chk("t6_second", grant_log[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
